// File: rtl/bka_pipe_addsub.sv
// bka_pipe_addsub: three-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, in_a, in_b, in_cin, in_sub (1 = a-b);
//        out_valid/out_ready, out_sum, out_cout (subtract: 1 = no borrow), out_ovf (signed), out_zero.
// Define BKA_PIPE_SATURATE_EN to clamp out_sum to the signed limit on overflow.
module bka_pipe_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int LV = $clog2(WIDTH);
  logic adv;
  logic [WIDTH-1:0] bx;
  logic s1_v, s1_c0;
  logic [WIDTH-1:0] s1_p, s1_g;
  logic s2_v, s2_c0;
  logic [WIDTH-1:0] s2_bp, s2_gg, s2_gp;
  logic [WIDTH-1:0] d_g, d_p, sum;
  logic [WIDTH:0] c;
  logic ovf;
`ifdef BKA_PIPE_SATURATE_EN
  logic s1_as, s2_as;
`endif
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  assign bx = in_sub ? ~in_b : in_b;
  // Up-sweep: level k merges span-2^(k-1) groups at indices where (i+1) is a multiple of 2^k.
  for (genvar k = 0; k <= LV; k++) begin : up
    logic [WIDTH-1:0] g, p;
    if (k == 0) begin : l0
      assign g = s1_g;
      assign p = s1_p;
    end else begin : lk
      for (genvar i = 0; i < WIDTH; i++) begin : b
        if ((i + 1) % (2 ** k) == 0) begin : n
          assign g[i] = up[k-1].g[i] | (up[k-1].p[i] & up[k-1].g[i-2**(k-1)]);
          assign p[i] = up[k-1].p[i] & up[k-1].p[i-2**(k-1)];
        end else begin : w
          assign g[i] = up[k-1].g[i];
          assign p[i] = up[k-1].p[i];
        end
      end
    end
  end
  // Down-sweep: fill the midpoints between completed prefixes, halving the span each level.
  for (genvar k = 0; k < LV; k++) begin : dn
    logic [WIDTH-1:0] g, p;
    if (k == 0) begin : l0
      assign g = s2_gg;
      assign p = s2_gp;
    end else begin : lk
      localparam int H = 2 ** (LV - 1 - k);
      for (genvar i = 0; i < WIDTH; i++) begin : b
        if (((i + 1) % (2 * H) == H) && (i + 1 > 2 * H)) begin : n
          assign g[i] = dn[k-1].g[i] | (dn[k-1].p[i] & dn[k-1].g[i-H]);
          assign p[i] = dn[k-1].p[i] & dn[k-1].p[i-H];
        end else begin : w
          assign g[i] = dn[k-1].g[i];
          assign p[i] = dn[k-1].p[i];
        end
      end
    end
  end
  assign d_g = dn[LV-1].g;
  assign d_p = dn[LV-1].p;
  // Carry-in enters as a generate at position -1 through one final cell per bit.
  assign c = {d_g | (d_p & {WIDTH{s2_c0}}), s2_c0};
  assign ovf = c[WIDTH] ^ c[WIDTH-1];
`ifdef BKA_PIPE_SATURATE_EN
  assign sum = ovf ? {s2_as, {(WIDTH-1){~s2_as}}} : s2_bp ^ c[WIDTH-1:0];
`else
  assign sum = s2_bp ^ c[WIDTH-1:0];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      out_valid <= 1'b0;
      out_sum <= '0;
      out_cout <= 1'b0;
      out_ovf <= 1'b0;
      out_zero <= 1'b0;
    end else if (adv) begin
      s1_v <= in_valid;
      s2_v <= s1_v;
      out_valid <= s2_v;
      out_sum <= sum;
      out_cout <= c[WIDTH];
      out_ovf <= ovf;
      out_zero <= ~|sum;
    end
  end
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_p <= in_a ^ bx;
      s1_g <= in_a & bx;
      s1_c0 <= in_sub | in_cin;
      s2_bp <= s1_p;
      s2_gg <= up[LV].g;
      s2_gp <= up[LV].p;
      s2_c0 <= s1_c0;
`ifdef BKA_PIPE_SATURATE_EN
      s1_as <= in_a[WIDTH-1];
      s2_as <= s1_as;
`endif
    end
  end
endmodule

// File: tb/tb_bka_pipe_addsub.sv
// tb_bka_pipe_addsub: scoreboard bench for bka_pipe_addsub at WIDTH 16 plus random runs at 4, 64 and 128.
module tb_bka_pipe_addsub;
  typedef struct packed {
    logic [127:0] sum;
    logic cout;
    logic ovf;
    logic zero;
  } exp_t;
  localparam int NW = 150;
`ifdef BKA_PIPE_SATURATE_EN
  localparam logic [15:0] SAT7 = 16'h7FFF;
  localparam logic [15:0] SAT8 = 16'h8000;
  localparam logic Z8 = 1'b0;
`else
  localparam logic [15:0] SAT7 = 16'h8000;
  localparam logic [15:0] SAT8 = 16'h0000;
  localparam logic Z8 = 1'b1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, in_cin = 1'b0, in_sub = 1'b0;
  logic [15:0] in_a = '0, in_b = '0, out_sum;
  logic out_valid, out_ready = 1'b1, out_cout, out_ovf, out_zero;
  logic wide_on = 1'b0;
  int total = 0, bad = 0;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  bka_pipe_addsub #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
  );
  function automatic exp_t model(int w, logic [127:0] a, logic [127:0] b, logic cin, logic sub);
    logic [128:0] m, am, bm, full, sh;
    logic as, bs, ss;
    exp_t r;
    m = {129{1'b1}} >> (129 - w);
    am = {1'b0, a} & m;
    bm = (sub ? ~{1'b0, b} : {1'b0, b}) & m;
    full = am + bm + {128'd0, sub | cin};
    sh = full >> w;
    r.cout = sh[0];
    sh = am >> (w - 1);
    as = sh[0];
    sh = bm >> (w - 1);
    bs = sh[0];
    sh = full >> (w - 1);
    ss = sh[0];
    r.ovf = (as == bs) && (ss != as);
    full = full & m;
`ifdef BKA_PIPE_SATURATE_EN
    if (r.ovf) full = as ? (129'd1 << (w - 1)) : (m >> 1);
`endif
    r.sum = full[127:0];
    r.zero = (full == 0);
    return r;
  endfunction
  function automatic logic [127:0] rnd(int w);
    logic [127:0] r = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 5))
      0: r = '0;
      1: r = '1;
      2: r = 128'd1 << (w - 1);
      3: r = (128'd1 << (w - 1)) - 1;
      default: ;
    endcase
    return r;
  endfunction
  always begin
    @(negedge clk);
    #1;
    if (out_valid && out_ready && !rst) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got=%h expected no output", out_sum);
      end else begin
        e = q.pop_front();
        if ({out_sum, out_cout, out_ovf, out_zero} !== {e.sum[15:0], e.cout, e.ovf, e.zero}) begin
          bad++;
          $display("FAIL scoreboard got sum=%h cout=%b ovf=%b zero=%b expected sum=%h cout=%b ovf=%b zero=%b",
                   out_sum, out_cout, out_ovf, out_zero, e.sum[15:0], e.cout, e.ovf, e.zero);
        end
      end
    end
  end
  for (genvar j = 0; j < 3; j++) begin : wide
    localparam int GW = j == 0 ? 4 : (j == 1 ? 64 : 128);
    logic iv = 1'b0, ir, ov, orr = 1'b1, cin = 1'b0, sub = 1'b0, co, of, zr;
    logic [GW-1:0] a = '0, b = '0, s;
    logic [127:0] t;
    exp_t wq[$];
    exp_t we;
    int sent = 0, got = 0;
    bka_pipe_addsub #(.WIDTH(GW)) u (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_a(a), .in_b(b),
      .in_cin(cin), .in_sub(sub), .out_valid(ov), .out_ready(orr),
      .out_sum(s), .out_cout(co), .out_ovf(of), .out_zero(zr)
    );
    always begin
      @(negedge clk);
      t = rnd(GW);
      a = t[GW-1:0];
      if ($urandom_range(0, 3) != 0) t = rnd(GW);
      b = t[GW-1:0];
      cin = $urandom_range(0, 1) == 1;
      sub = $urandom_range(0, 1) == 1;
      iv = wide_on && sent < NW && $urandom_range(0, 3) != 0;
      orr = !wide_on || $urandom_range(0, 3) != 0;
      #1;
      if (iv && ir) begin
        wq.push_back(model(GW, 128'(a), 128'(b), cin, sub));
        sent++;
      end
      if (ov && orr && !rst) begin
        total++;
        got++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL wide%0d_unexpected got=%h expected no output", GW, s);
        end else begin
          we = wq.pop_front();
          if ({s, co, of, zr} !== {we.sum[GW-1:0], we.cout, we.ovf, we.zero}) begin
            bad++;
            $display("FAIL wide%0d got sum=%h cout=%b ovf=%b zero=%b expected sum=%h cout=%b ovf=%b zero=%b",
                     GW, s, co, of, zr, we.sum[GW-1:0], we.cout, we.ovf, we.zero);
          end
        end
      end
    end
  end
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    int n = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_cin = cin;
      in_sub = sub;
      #1;
      if (in_ready) begin
        q.push_back(model(16, 128'(a), 128'(b), cin, sub));
        done = 1'b1;
      end else if (++n > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout in_ready=%b expected 1 within 50 cycles", in_ready);
        done = 1'b1;
      end
    end
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d expected 0", name, q.size());
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({out_valid, out_sum, out_cout, out_ovf, out_zero, in_ready} !== {1'b0, 16'h0, 3'b000, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got v=%b sum=%h c=%b o=%b z=%b rdy=%b expected 0/0000/0/0/0/1",
               out_valid, out_sum, out_cout, out_ovf, out_zero, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release got v=%b rdy=%b expected 0/1", out_valid, in_ready);
    end
  endtask
  task automatic test_directed();
    logic [15:0] ta[6], tb[6], es[6];
    logic tc[6], tsub[6], ec[6], eo[6], ez[6];
    int n;
    ta = '{16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000, 16'h1234};
    tb = '{16'h0001, 16'h0007, 16'h0005, 16'h0001, 16'h8000, 16'h0001};
    tc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tsub = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    es = '{16'h0000, 16'hFFFE, 16'h0002, SAT7, SAT8, 16'h1236};
    ec = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    eo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ez = '{1'b1, 1'b0, 1'b0, 1'b0, Z8, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(ta[i], tb[i], tc[i], tsub[i]);
      idle();
      n = 0;
      while (!out_valid && n < 10) begin
        @(negedge clk);
        #1;
        n++;
      end
      total++;
      if (out_valid !== 1'b1 || {out_sum, out_cout, out_ovf, out_zero} !== {es[i], ec[i], eo[i], ez[i]}) begin
        bad++;
        $display("FAIL directed%0d got v=%b sum=%h c=%b o=%b z=%b expected v=1 sum=%h c=%b o=%b z=%b",
                 i, out_valid, out_sum, out_cout, out_ovf, out_zero, es[i], ec[i], eo[i], ez[i]);
      end
    end
  endtask
  task automatic test_latency();
    out_ready = 1'b1;
    send(16'h00FF, 16'h0F0F, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL latency_early got v=%b rdy=%b expected 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL latency_edge3 got v=%b expected 1", out_valid);
    end
    drain("latency");
  endtask
  task automatic test_back_to_back();
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(16'(i * 4099 + 3), 16'(i * 7919 + 11), i % 2 == 1, i % 3 == 0);
        idle();
      end
      begin
        int n = 0;
        logic [18:0] snap = '0, cur;
        while (!out_valid && n < 20) begin
          @(negedge clk);
          #1;
          n++;
        end
        total++;
        if (out_valid !== 1'b1) begin
          bad++;
          $display("FAIL b2b_first got v=%b expected 1", out_valid);
        end else begin
          for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            cur = {out_sum, out_cout, out_ovf, out_zero};
            if (c == 0) snap = cur;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || (c > 0 && cur !== snap)) begin
              bad++;
              $display("FAIL b2b_stall%0d got rdy=%b v=%b data=%h expected rdy=0 v=1 data=%h",
                       c, in_ready, out_valid, cur, snap);
            end
          end
          @(negedge clk);
          out_ready = 1'b1;
        end
      end
    join
    drain("b2b");
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h0001, 1'b0, 1'b1);
    send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_a = 16'hDEAD;
    in_b = 16'hBEEF;
    out_ready = 1'b0;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid got v=%b rdy=%b expected 0/1", out_valid, in_ready);
    end
    repeat (5) @(negedge clk);
    send(16'h0100, 16'h0023, 1'b0, 1'b0);
    send(16'h0040, 16'h0041, 1'b0, 1'b1);
    idle();
    drain("reset_mid");
  endtask
  task automatic test_random();
    int rem = 300, n = 0;
    logic [127:0] t;
    while ((rem > 0 || q.size() != 0) && n < 5000) begin
      @(negedge clk);
      t = rnd(16);
      in_a = t[15:0];
      if ($urandom_range(0, 3) != 0) t = rnd(16);
      in_b = t[15:0];
      in_cin = $urandom_range(0, 1) == 1;
      in_sub = $urandom_range(0, 1) == 1;
      in_valid = rem > 0 && $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 9) < 7;
      #1;
      if (in_valid && in_ready) begin
        q.push_back(model(16, 128'(in_a), 128'(in_b), in_cin, in_sub));
        rem--;
      end
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++;
    if (rem != 0 || q.size() != 0) begin
      bad++;
      $display("FAIL random_complete unsent=%0d pending=%0d expected 0/0", rem, q.size());
    end
  endtask
  task automatic test_wide();
    int n = 0;
    wide_on = 1'b1;
    while ((wide[0].got < NW || wide[1].got < NW || wide[2].got < NW) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    wide_on = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (wide[0].got !== NW || wide[0].wq.size() != 0) begin
      bad++;
      $display("FAIL wide4_count got=%0d pending=%0d expected %0d/0", wide[0].got, wide[0].wq.size(), NW);
    end
    total++;
    if (wide[1].got !== NW || wide[1].wq.size() != 0) begin
      bad++;
      $display("FAIL wide64_count got=%0d pending=%0d expected %0d/0", wide[1].got, wide[1].wq.size(), NW);
    end
    total++;
    if (wide[2].got !== NW || wide[2].wq.size() != 0) begin
      bad++;
      $display("FAIL wide128_count got=%0d pending=%0d expected %0d/0", wide[2].got, wide[2].wq.size(), NW);
    end
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
